// File: rtl/exe_pkg.sv
// Shared types for the multi-cycle execute stage.
// EXE_DIV_EN adds DIVU/REMU to the iterative unit.
package exe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLT   = 4'd2,
    ALU_SLTU  = 4'd3,
    ALU_AND   = 4'd4,
    ALU_OR    = 4'd5,
    ALU_XOR   = 4'd6,
    ALU_NOR   = 4'd7,
    ALU_SLL   = 4'd8,
    ALU_SRL   = 4'd9,
    ALU_SRA   = 4'd10,
    ALU_LUI   = 4'd11,
    ALU_MULLO = 4'd12,
    ALU_MULHU = 4'd13,
    ALU_DIVU  = 4'd14,
    ALU_REMU  = 4'd15
  } aluop_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  function automatic logic is_iterative(input logic [3:0] op);
`ifdef EXE_DIV_EN
    return (op == ALU_MULLO) || (op == ALU_MULHU) ||
           (op == ALU_DIVU)  || (op == ALU_REMU);
`else
    return (op == ALU_MULLO) || (op == ALU_MULHU);
`endif
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU for op codes 0-11.
// Codes 12-15 produce zero here.
module alu
  import exe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int SH_W = $clog2(DATA_W);

  logic [SH_W-1:0] sh;
  logic            lt_s;
  logic            lt_u;

  assign sh   = b[SH_W-1:0];
  assign lt_s = $signed(a) < $signed(b);
  assign lt_u = a < b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:  result = a + b;
      ALU_SUB:  result = a - b;
      ALU_SLT:  result = {{(DATA_W-1){1'b0}}, lt_s};
      ALU_SLTU: result = {{(DATA_W-1){1'b0}}, lt_u};
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLL:  result = a << sh;
      ALU_SRL:  result = a >> sh;
      ALU_SRA:  result = $unsigned($signed(a) >>> sh);
      ALU_LUI:  result = b << (DATA_W / 2);
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/exe_muldiv_iter.sv
// Radix-2 iterative multiplier (and restoring divider with EXE_DIV_EN).
// One step per cycle; done flags the cycle of the final step.
module exe_muldiv_iter
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] result
);

  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] opnd;
  logic [DATA_W-1:0] hi_nxt;
  logic [DATA_W-1:0] lo_nxt;
  logic [DATA_W:0]   sum;
  logic              sel_hi;
  logic              start_hi;
  logic              start_div;

  // {hi,lo} shifts right; lo starts as the multiplier
  assign sum = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);

`ifdef EXE_DIV_EN
  logic              is_div;
  logic              ge;
  logic [DATA_W:0]   shifted;
  logic [DATA_W-1:0] diff;

  // hi is the partial remainder, lo the dividend/quotient
  assign shifted   = {hi, lo[DATA_W-1]};
  assign ge        = shifted >= {1'b0, opnd};
  assign diff      = shifted[DATA_W-1:0] - opnd;
  assign hi_nxt    = is_div ? (ge ? diff : shifted[DATA_W-1:0])
                            : sum[DATA_W:1];
  assign lo_nxt    = is_div ? {lo[DATA_W-2:0], ge}
                            : {sum[0], lo[DATA_W-1:1]};
  assign start_div = (op == ALU_DIVU) || (op == ALU_REMU);
  assign start_hi  = (op == ALU_MULHU) || (op == ALU_REMU);
`else
  assign hi_nxt    = sum[DATA_W:1];
  assign lo_nxt    = {sum[0], lo[DATA_W-1:1]};
  assign start_div = 1'b0;
  assign start_hi  = (op == ALU_MULHU);
`endif

  assign done   = (cnt == CNT_W'(1));
  assign result = sel_hi ? hi_nxt : lo_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opnd   <= '0;
      sel_hi <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt    <= CNT_W'(DATA_W);
      hi     <= '0;
      lo     <= start_div ? a : b;
      opnd   <= start_div ? b : a;
      sel_hi <= start_hi;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
      hi  <= hi_nxt;
      lo  <= lo_nxt;
    end
  end

`ifdef EXE_DIV_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      is_div <= 1'b0;
    end else if (start && !clear) begin
      is_div <= start_div;
    end
  end
`endif

endmodule

// File: rtl/execute_stage_mc.sv
// Execute stage with valid/allowin handshake and iterative mul/div.
// EXE_DIV_EN enables the iterative DIVU/REMU path.
module execute_stage_mc
  import exe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              de_valid,
  output logic              de_allowin,
  input  logic [3:0]        de_aluop,
  input  logic [DATA_W-1:0] de_alusrc1,
  input  logic [DATA_W-1:0] de_alusrc2,
  input  logic              de_wen,
  input  logic [REG_AW-1:0] de_regsrc,
  input  logic              de_is_load,
  input  logic              ms_allowin,
  output logic              exe_to_ms_valid,
  output logic [DATA_W-1:0] exe_alu_result,
  output logic              exe_wen,
  output logic [REG_AW-1:0] exe_regsrc,
  output logic              exe_is_load,
  output logic              exe_busy
);

  fsm_t              state;
  fsm_t              state_nxt;
  logic              exe_valid;
  logic              iter_q;
  logic              ready_go;
  logic              accept;
  logic              de_iter;
  logic              iter_done;
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] iter_res;

  assign de_iter = is_iterative(de_aluop);
  assign accept  = de_valid && de_allowin && !flush;

  alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (de_aluop),
    .a      (de_alusrc1),
    .b      (de_alusrc2),
    .result (alu_res)
  );

  exe_muldiv_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .start  (accept && de_iter),
    .op     (de_aluop),
    .a      (de_alusrc1),
    .b      (de_alusrc2),
    .done   (iter_done),
    .result (iter_res)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (accept && de_iter) state_nxt = BUSY;
        BUSY: if (iter_done) state_nxt = DONE;
        DONE: if (ms_allowin) begin
          state_nxt = (accept && de_iter) ? BUSY : IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    exe_busy        = (state == BUSY);
    ready_go        = iter_q ? (state == DONE) : 1'b1;
    de_allowin      = !exe_valid || (ready_go && ms_allowin);
    exe_to_ms_valid = exe_valid && ready_go && !flush;
  end

  // control fields follow the instruction; result lands at accept or at the last step
  always_ff @(posedge clk) begin
    if (reset) begin
      exe_valid      <= 1'b0;
      iter_q         <= 1'b0;
      exe_alu_result <= '0;
      exe_wen        <= 1'b0;
      exe_regsrc     <= '0;
      exe_is_load    <= 1'b0;
    end else begin
      if (flush) begin
        exe_valid <= 1'b0;
      end else if (accept) begin
        exe_valid <= 1'b1;
      end else if (ready_go && ms_allowin) begin
        exe_valid <= 1'b0;
      end
      if (accept) begin
        iter_q         <= de_iter;
        exe_alu_result <= alu_res;
        exe_wen        <= de_wen;
        exe_regsrc     <= de_regsrc;
        exe_is_load    <= de_is_load;
      end else if (!flush && state == BUSY && iter_done) begin
        exe_alu_result <= iter_res;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc with a cycle-level reference model.
// Divide checks follow EXE_DIV_EN.
module tb_execute_stage_mc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        de_valid = 1'b0;
  logic        de_allowin;
  logic [3:0]  de_aluop = 4'd0;
  logic [31:0] de_alusrc1 = 32'd0;
  logic [31:0] de_alusrc2 = 32'd0;
  logic        de_wen = 1'b0;
  logic [4:0]  de_regsrc = 5'd0;
  logic        de_is_load = 1'b0;
  logic        ms_allowin = 1'b1;
  logic        exe_to_ms_valid;
  logic [31:0] exe_alu_result;
  logic        exe_wen;
  logic [4:0]  exe_regsrc;
  logic        exe_is_load;
  logic        exe_busy;

  int n_tests = 0;
  int n_fail  = 0;

  execute_stage_mc #(
    .DATA_W (32),
    .REG_AW (5),
    .CNT_W  (6)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .de_valid        (de_valid),
    .de_allowin      (de_allowin),
    .de_aluop        (de_aluop),
    .de_alusrc1      (de_alusrc1),
    .de_alusrc2      (de_alusrc2),
    .de_wen          (de_wen),
    .de_regsrc       (de_regsrc),
    .de_is_load      (de_is_load),
    .ms_allowin      (ms_allowin),
    .exe_to_ms_valid (exe_to_ms_valid),
    .exe_alu_result  (exe_alu_result),
    .exe_wen         (exe_wen),
    .exe_regsrc      (exe_regsrc),
    .exe_is_load     (exe_is_load),
    .exe_busy        (exe_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // reference results straight from the operation definitions
  function automatic logic [31:0] golden(input logic [3:0] op,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd3:  return (a < b) ? 32'd1 : 32'd0;
      4'd4:  return a & b;
      4'd5:  return a | b;
      4'd6:  return a ^ b;
      4'd7:  return ~(a | b);
      4'd8:  return a << b[4:0];
      4'd9:  return a >> b[4:0];
      4'd10: return $unsigned($signed(a) >>> b[4:0]);
      4'd11: return {b[15:0], 16'h0000};
      4'd12: return p[31:0];
      4'd13: return p[63:32];
`ifdef EXE_DIV_EN
      4'd14: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd15: return (b == 32'd0) ? a : a % b;
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit multi_cycle(input logic [3:0] op);
`ifdef EXE_DIV_EN
    return op >= 4'd12;
`else
    return (op == 4'd12) || (op == 4'd13);
`endif
  endfunction

  bit          m_live = 1'b0;
  bit          m_valid = 1'b0;
  bit          m_rst = 1'b0;
  int          m_wait = 0;
  logic [31:0] m_res = 32'd0;
  logic        m_wen = 1'b0;
  logic [4:0]  m_rd = 5'd0;
  logic        m_ld = 1'b0;

  // occupancy + remaining-latency model of the stage
  always @(posedge clk) begin : model
    bit acc;
    acc = de_valid && !flush &&
          (!m_valid || (m_wait == 0 && ms_allowin));
    m_live <= 1'b1;
    if (reset) begin
      m_valid <= 1'b0;
      m_wait  <= 0;
      m_res   <= 32'd0;
      m_wen   <= 1'b0;
      m_rd    <= 5'd0;
      m_ld    <= 1'b0;
      m_rst   <= 1'b1;
    end else if (flush) begin
      m_valid <= 1'b0;
      m_wait  <= 0;
    end else if (acc) begin
      m_valid <= 1'b1;
      m_wait  <= multi_cycle(de_aluop) ? 32 : 0;
      m_res   <= golden(de_aluop, de_alusrc1, de_alusrc2);
      m_wen   <= de_wen;
      m_rd    <= de_regsrc;
      m_ld    <= de_is_load;
      m_rst   <= 1'b0;
    end else if (m_wait > 0) begin
      m_wait <= m_wait - 1;
    end else if (m_valid && ms_allowin) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin : compare
    bit ev;
    bit ea;
    bit eb;
    if (m_live) begin
      ea = !m_valid || (m_wait == 0 && ms_allowin);
      ev = m_valid && m_wait == 0 && !flush;
      eb = m_valid && m_wait > 0;
      chk("cyc_valid", 32'(exe_to_ms_valid), 32'(ev));
      chk("cyc_allowin", 32'(de_allowin), 32'(ea));
      chk("cyc_busy", 32'(exe_busy), 32'(eb));
      if (ev || m_rst) begin
        chk("cyc_result", exe_alu_result, m_res);
        chk("cyc_wen", 32'(exe_wen), 32'(m_wen));
        chk("cyc_regsrc", 32'(exe_regsrc), 32'(m_rd));
        chk("cyc_is_load", 32'(exe_is_load), 32'(m_ld));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // call at posedge+1; returns at posedge+1 just after the accept edge
  task automatic send(input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input logic wen, input logic ld);
    bit ok;
    ok = 1'b0;
    de_aluop   = op;
    de_alusrc1 = a;
    de_alusrc2 = b;
    de_regsrc  = rd;
    de_wen     = wen;
    de_is_load = ld;
    de_valid   = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = de_allowin && !flush;
      step();
    end
    de_valid = 1'b0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // k counts cycles after the accept edge until the output is valid
  task automatic wait_valid(output int k);
    k = 1;
    settle();
    while (!exe_to_ms_valid && k < 200) begin
      settle();
      k++;
    end
    if (k >= 200) chk("wait_valid_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t alu_vecs[11] = '{
    '{4'd1,  32'h0000_0003, 32'h0000_000A, 32'hFFFF_FFF9},
    '{4'd2,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001},
    '{4'd3,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000},
    '{4'd4,  32'hF0F0_FFFF, 32'h0FF0_00FF, 32'h00F0_00FF},
    '{4'd5,  32'hF000_0000, 32'h0000_000F, 32'hF000_000F},
    '{4'd6,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F},
    '{4'd7,  32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F},
    '{4'd8,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000},
    '{4'd9,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000},
    '{4'd10, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000},
    '{4'd11, 32'h0000_0000, 32'h0000_ABCD, 32'hABCD_0000}
  };

`ifdef EXE_DIV_EN
  vec_t div_vecs[4] = '{
    '{4'd14, 32'd100,       32'd7, 32'd14},
    '{4'd15, 32'd100,       32'd7, 32'd2},
    '{4'd14, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF},
    '{4'd15, 32'h0000_1234, 32'd0, 32'h0000_1234}
  };
`endif

  initial begin
    int k;
    int rises;
    repeat (3) step();
    settle();
    chk("rst_valid", 32'(exe_to_ms_valid), 32'd0);
    chk("rst_busy", 32'(exe_busy), 32'd0);
    chk("rst_result", exe_alu_result, 32'd0);
    chk("rst_wen", 32'(exe_wen), 32'd0);
    chk("rst_regsrc", 32'(exe_regsrc), 32'd0);
    chk("rst_is_load", 32'(exe_is_load), 32'd0);
    step();
    reset = 1'b0;

    send(4'd0, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0);
    settle();
    chk("add_valid", 32'(exe_to_ms_valid), 32'd1);
    chk("add_result", exe_alu_result, 32'd12);
    chk("add_regsrc", 32'(exe_regsrc), 32'd3);
    chk("add_wen", 32'(exe_wen), 32'd1);
    step();

    send(4'd12, 32'h0001_0003, 32'h0000_0010, 5'd4, 1'b1, 1'b0);
    wait_valid(k);
    chk("mullo_latency", 32'(k), 32'd33);
    chk("mullo_result", exe_alu_result, 32'h0010_0030);
    step();

    send(4'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0);
    wait_valid(k);
    chk("mulhu_latency", 32'(k), 32'd33);
    chk("mulhu_result", exe_alu_result, 32'hFFFF_FFFE);
    step();

`ifdef EXE_DIV_EN
    foreach (div_vecs[i]) begin
      send(div_vecs[i].op, div_vecs[i].a, div_vecs[i].b, 5'd6, 1'b1, 1'b0);
      wait_valid(k);
      chk("div_latency", 32'(k), 32'd33);
      chk("div_result", exe_alu_result, div_vecs[i].exp);
      step();
    end
`else
    send(4'd14, 32'd100, 32'd7, 5'd6, 1'b1, 1'b0);
    settle();
    chk("divu_off_valid", 32'(exe_to_ms_valid), 32'd1);
    chk("divu_off_busy", 32'(exe_busy), 32'd0);
    chk("divu_off_result", exe_alu_result, 32'd0);
    step();
`endif

    foreach (alu_vecs[i]) begin
      send(alu_vecs[i].op, alu_vecs[i].a, alu_vecs[i].b, 5'd8, 1'b0, 1'b1);
      settle();
      chk("alu_vec_result", exe_alu_result, alu_vecs[i].exp);
      step();
    end

    ms_allowin = 1'b0;
    send(4'd0, 32'd20, 32'd22, 5'd7, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_result", exe_alu_result, 32'd42);
      chk("stall_allowin", 32'(de_allowin), 32'd0);
      step();
    end
    ms_allowin = 1'b1;
    send(4'd1, 32'd50, 32'd10, 5'd9, 1'b0, 1'b0);
    settle();
    chk("b2b_result", exe_alu_result, 32'd40);
    chk("b2b_regsrc", 32'(exe_regsrc), 32'd9);
    step();

    ms_allowin = 1'b0;
    send(4'd12, 32'd7, 32'd6, 5'd10, 1'b1, 1'b0);
    wait_valid(k);
    step();
    repeat (3) step();
    settle();
    chk("mul_stall_result", exe_alu_result, 32'd42);
    chk("mul_stall_valid", 32'(exe_to_ms_valid), 32'd1);
    step();
    ms_allowin = 1'b1;
    send(4'd0, 32'd1, 32'd1, 5'd11, 1'b1, 1'b0);
    settle();
    chk("mul_b2b_result", exe_alu_result, 32'd2);
    step();

    send(4'd12, 32'd3, 32'd5, 5'd12, 1'b1, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    settle();
    chk("flush_valid", 32'(exe_to_ms_valid), 32'd0);
    step();
    flush = 1'b0;
    settle();
    chk("flush_busy", 32'(exe_busy), 32'd0);
    chk("flush_allowin", 32'(de_allowin), 32'd1);
    rises = 0;
    repeat (40) begin
      settle();
      if (exe_to_ms_valid) rises++;
    end
    chk("flush_no_valid", 32'(rises), 32'd0);
    step();

    send(4'd13, 32'hFFFF_FFFF, 32'd2, 5'd13, 1'b1, 1'b1);
    repeat (5) step();
    reset = 1'b1;
    step();
    chk("rst2_valid", 32'(exe_to_ms_valid), 32'd0);
    chk("rst2_busy", 32'(exe_busy), 32'd0);
    chk("rst2_result", exe_alu_result, 32'd0);
    chk("rst2_wen", 32'(exe_wen), 32'd0);
    chk("rst2_regsrc", 32'(exe_regsrc), 32'd0);
    chk("rst2_is_load", 32'(exe_is_load), 32'd0);
    reset = 1'b0;

    send(4'd0, 32'd100, 32'd23, 5'd14, 1'b1, 1'b0);
    settle();
    chk("post_rst_add", exe_alu_result, 32'd123);
    step();
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/execute_stage_mc.md
Name: execute_stage_mc

Overview:
Parametrised successor execute stage for the 5-stage CPU. Sits between decode and memory stages with a valid/allowin handshake, so the stage can stall. Single-cycle ALU ops complete in one cycle. Iterative multiply (and optional divide) ops occupy the stage for multiple cycles under an internal FSM. The stage also forwards write-back control (wen, regsrc, is_load) alongside the result.

Parameters:
DATA_W, 32, operand/result width (≥8, even)
REG_AW, 5, destination register number width
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > DATA_W

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
flush  in  1  discard in-flight instruction (exception/branch redirect)
de_valid  in  1  decode presents an instruction
de_allowin  out  1  stage can accept this cycle (combinational)
de_aluop  in  4  operation code (package enum)
de_alusrc1  in  DATA_W  operand A
de_alusrc2  in  DATA_W  operand B
de_wen  in  1  register write enable
de_regsrc  in  REG_AW  destination register number
de_is_load  in  1  instruction is a load
ms_allowin  in  1  memory stage can accept
exe_to_ms_valid  out  1  result valid toward memory stage
exe_alu_result  out  DATA_W  registered result
exe_wen  out  1  registered wen
exe_regsrc  out  REG_AW  registered destination
exe_is_load  out  1  registered is_load
exe_busy  out  1  iterative unit active (for hazard/stall logic)

Behaviour:
- Reset values: exe_to_ms_valid=0, exe_busy=0, exe_alu_result=0, exe_wen=0, exe_regsrc=0, exe_is_load=0, FSM=IDLE, counter=0.
- Internal exe_valid: holds stage occupancy. ready_go = 1 for single-cycle ops; for iterative ops, ready_go = (FSM==DONE).
- de_allowin = !exe_valid || (ready_go && ms_allowin).
- exe_to_ms_valid = exe_valid && ready_go && !flush.
- Accept occurs when de_valid && de_allowin && !flush. On accept: exe_valid<=1 and the control fields are latched.
- Single-cycle ops (codes 0–11, existing alu encoding): result is latched at the accept edge. Output is valid the next cycle (latency 1, same as the previous generation).
- Iterative ops: 12 MULLO, 13 MULHU, 14 DIVU, 15 REMU (all unsigned).
  - On accept: operands are latched, FSM goes IDLE→BUSY, counter<=DATA_W.
  - BUSY: one radix-2 step per cycle; counter decrements. When counter==1, step completes and FSM goes to DONE with the result written.
  - exe_to_ms_valid first rises DATA_W+1 cycles after the accept edge.
  - DONE→IDLE when ms_allowin is high. Back-to-back accept in that same cycle is allowed.
- exe_busy = (FSM==BUSY).
- Stall: while exe_to_ms_valid && !ms_allowin, all outputs are held stable.
- No accept when !de_valid. exe_valid clears on handoff if no new accept.
- flush: has priority over accept and handoff. At the next edge exe_valid<=0, FSM<=IDLE, counter<=0, and exe_to_ms_valid drops immediately (combinational). Data registers may retain stale values.
- MULHU returns the upper DATA_W bits of the 2*DATA_W product. MULLO returns the lower DATA_W bits.
- Divide by zero: DIVU returns all-ones; REMU returns the dividend. No trap.
- Reset asserted mid-iteration returns everything to reset values at that edge.

Optional Feature:
Macro EXE_DIV_EN.
- Defined: DIVU/REMU use the iterative restoring divider, same FSM and latency as multiply.
- Undefined: divider logic is absent. DIVU/REMU are treated as single-cycle ops with result 0 (latency 1), and exe_busy never asserts for them.

Decomposition:
- Package exe_pkg holds:
  - the aluop enum (ALU_ADD..ALU_REMU, 4-bit)
  - the FSM state enum (IDLE/BUSY/DONE)
  - the helper function is_iterative(op), which respects EXE_DIV_EN
- One sub-module, exe_muldiv_iter:
  - Inputs: start, op, a, b.
  - Outputs: done, result.
  - Contains the counter and shift registers.
  - The outer stage owns the handshake, flush and control-field registers.
  - The existing alu module is instantiated unchanged for codes 0–11.

Test Plan:
- ADD 5+7, ms_allowin=1 → exe_to_ms_valid high 1 cycle after accept, exe_alu_result=12, exe_regsrc/wen/is_load echoed.
- MULLO 0x0001_0003×0x0000_0010, DATA_W=32 → result 0x0010_0030 appears exactly 33 cycles after accept. de_allowin=0 and exe_busy=1 throughout BUSY.
- MULHU 0xFFFF_FFFF×0xFFFF_FFFF → 0xFFFF_FFFE.
- With EXE_DIV_EN:
  - DIVU 100/7 → 14; REMU 100/7 → 2.
  - DIVU x/0 with x=0x1234 → 0xFFFF_FFFF; REMU x/0 → 0x1234.
- ADD accepted while ms_allowin=0 for 3 cycles → outputs held constant, de_allowin=0. When ms_allowin rises, handoff and a new accept happen in the same cycle.
- MULLO accepted, flush at cycle 10 of BUSY → exe_to_ms_valid never rises, FSM=IDLE next cycle, de_allowin=1. Reset asserted mid-BUSY → all outputs 0 next cycle.
